// File: rtl/sbox_result_collector.sv
// Capture stage behind the 16-bit S-box pipeline: tags each issued word, grabs the S-box
// output LATENCY clocks later into a small FIFO, and gates issue on FIFO credits.
module sbox_result_collector #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [15:0]                sbox_data,
    output logic                       out_valid,
    output logic [15:0]                out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       drop_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LATENCY + 1);
    localparam int SW = $clog2(DEPTH + LATENCY + 1);

    logic [LATENCY-1:0] tag;
    logic [LATENCY-1:0] tag_next;
    logic [IW-1:0]      inflight;
    logic [SW-1:0]      credit_used;
    logic               issue_fire;
    logic               cap;
    logic               pop;

    logic [15:0]        mem [DEPTH];
    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;

    assign cap = tag[LATENCY-1];

    // Every tag still in the shift register holds a FIFO slot in reserve, including
    // the one being captured this edge.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + IW'(tag[i]);
        end
    end

    assign credit_used = SW'(level) + SW'(inflight);
    assign issue_ready = credit_used < SW'(DEPTH);
    assign issue_fire  = issue_valid & issue_ready;

    always_comb begin
        tag_next    = '0;
        tag_next[0] = issue_fire;
        for (int i = 1; i < LATENCY; i++) begin
            tag_next[i] = tag[i-1];
        end
    end

    assign out_valid = (level != '0);
    assign out_data  = out_valid ? mem[rptr] : 16'h0000;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag <= '0;
        end else begin
            tag <= tag_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 16'h0000;
            end
            wptr <= '0;
        end else if (cap) begin
            mem[wptr] <= sbox_data;
            wptr      <= wptr + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr <= '0;
        end else if (pop) begin
            rptr <= rptr + AW'(1);
        end
    end

    // Simultaneous capture and pop leaves occupancy unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= '0;
        end else begin
            case ({cap, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_err <= 1'b0;
        end else if (issue_valid && !issue_ready) begin
            drop_err <= 1'b1;
        end
    end

endmodule
